// File: rtl/perceptron_driver.sv
// Sequential front/back-end for the two-input perceptron: holds weights/bias,
// pairs the x1/x2 input word stream into operands and emits the indexed decision.
module perceptron_driver #(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [9:0]       cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_data,
    output logic [9:0]       x1,
    output logic [9:0]       x2,
    output logic [9:0]       w1,
    output logic [9:0]       w2,
    output logic [9:0]       bias,
    input  logic             y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [IDX_W-1:0] out_idx
);

    typedef enum logic [1:0] {S_X1, S_X2, S_EVAL, S_OUT} state_t;

    state_t     state, state_nxt;
    logic [9:0] cfg_w1, cfg_w2, cfg_b;
    logic [9:0] x1_stg;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            S_X1: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_X2;
            end
            S_X2: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_EVAL;
            end
            S_EVAL: state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) state_nxt = S_X1;
            end
            default: state_nxt = S_X1;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_X1;
            cfg_w1    <= '0;
            cfg_w2    <= '0;
            cfg_b     <= '0;
            x1_stg    <= '0;
            x1        <= '0;
            x2        <= '0;
            w1        <= '0;
            w2        <= '0;
            bias      <= '0;
            out_y     <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_we) begin
                unique case (cfg_addr)
                    2'd0:    cfg_w1 <= cfg_data;
                    2'd1:    cfg_w2 <= cfg_data;
                    2'd2:    cfg_b  <= cfg_data;
                    default: ;
                endcase
            end
            if (state == S_X1 && in_valid) x1_stg <= in_data;
            // Snapshot reads the pre-edge cfg_* values, so a same-cycle write lands next sample.
            if (state == S_X2 && in_valid) begin
                x1   <= x1_stg;
                x2   <= in_data;
                w1   <= cfg_w1;
                w2   <= cfg_w2;
                bias <= cfg_b;
            end
            if (state == S_EVAL) begin
                out_y     <= y_in;
                out_valid <= 1'b1;
            end
            if (state == S_OUT && out_ready) begin
                out_valid <= 1'b0;
                out_idx   <= out_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_perceptron_driver.sv
// Randomized scoreboard bench for perceptron_driver; a behavioural perceptron
// (sum >= 0 fires) closes the loop on y_in.
module tb_perceptron_driver;

    localparam int unsigned IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [9:0]       cfg_data;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       in_data;
    logic [9:0]       x1, x2, w1, w2, bias;
    logic             y_in;
    logic             out_valid;
    logic             out_ready;
    logic             out_y;
    logic [IDX_W-1:0] out_idx;

    perceptron_driver #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .x1(x1), .x2(x2), .w1(w1), .w2(w2), .bias(bias), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Behavioural perceptron stub driven by the operand outputs.
    int psum;
    always_comb begin
        psum = int'($signed(x1)) * int'($signed(w1)) + int'($signed(x2)) * int'($signed(w2))
             + int'($signed(bias));
        y_in = (psum >= 0);
    end

    typedef struct { int y; int idx; } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;
    int mw1, mw2, mb, midx;
    int or_mode;      // 0: out_ready held 1, 1: random, 2: bench drives directly
    int cyc = 0;
    int last_pop;
    bit have_last;
    bit chk_spacing = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (or_mode == 0) out_ready = 1'b1;
            else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every presented result is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("out_y", int'(out_y), expq[0].y);
                chk("out_idx", int'(out_idx), expq[0].idx);
                chk("in_ready_busy", int'(in_ready), 0);
                if (out_ready) begin
                    void'(expq.pop_front());
                    if (chk_spacing && have_last) chk("sample_spacing", cyc - last_pop, 4);
                    last_pop  = cyc;
                    have_last = 1'b1;
                end
            end
        end
    end

    function automatic int sx(input logic [9:0] v);
        return int'($signed(v));
    endfunction

    task automatic push_exp(input int a, input int b);
        exp_t e;
        e.y   = ((mw1 * a + mw2 * b + mb) >= 0) ? 1 : 0;
        e.idx = midx;
        expq.push_back(e);
        midx = (midx + 1) % (1 << IDX_W);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_in_rst", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cfg_we   = 1'b0;
        expq.delete();
        mw1 = 0; mw2 = 0; mb = 0; midx = 0;
        have_last = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int val);
        logic [9:0] v;
        v        = 10'(val);
        cfg_we   = 1'b1;
        cfg_addr = 2'(addr);
        cfg_data = v;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (addr == 0) mw1 = sx(v);
        else if (addr == 1) mw2 = sx(v);
        else if (addr == 2) mb = sx(v);
    endtask

    task automatic send_word(input int d, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 10'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = 10'(d);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 10'($urandom);
    endtask

    task automatic send_sample(input int a, input int b, input int gap);
        send_word(a, gap);
        send_word(b, gap);
        push_exp(sx(10'(a)), sx(10'(b)));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        chk("drain", int'(ok), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; or_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // AND function, back-to-back stream
        cfg_write(0, 2); cfg_write(1, 2); cfg_write(2, -3);
        chk_spacing = 1'b1; have_last = 1'b0;
        send_sample(0, 0, 0); send_sample(0, 1, 0);
        send_sample(1, 0, 0); send_sample(1, 1, 0);
        wait_drain();
        chk_spacing = 1'b0;

        // Back-pressure
        do_reset();
        cfg_write(0, 1); cfg_write(1, 1); cfg_write(2, 0);
        or_mode = 2; out_ready = 1'b0;
        send_sample(5, -2, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_valid_seen", int'(out_valid), 1);
        repeat (9) begin
            @(negedge clk);
            chk("bp_valid_held", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_cleared", int'(out_valid), 0);
        chk("bp_idx_after", int'(out_idx), 1);
        or_mode = 0;

        // Config write racing the x2 snapshot
        do_reset();
        cfg_write(0, 1); cfg_write(1, 1); cfg_write(2, 0);
        send_word(1, 0);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 10'(-10);
        send_word(1, 0);
        cfg_we = 1'b0;
        push_exp(1, 1);
        mb = -10;
        send_sample(1, 1, 0);
        wait_drain();

        // Input gaps, random config and random out_ready
        do_reset();
        or_mode = 1;
        for (int s = 0; s < 20; s++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)) - 512);
            send_sample(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 2);
        end
        wait_drain();
        or_mode = 0;

        // Reset mid-sample; a config write under reset must be dropped
        do_reset();
        send_word(7, 0);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 10'd100;
        do_reset();
        @(negedge clk);
        chk("mid_x1", int'(x1), 0);
        chk("mid_x2", int'(x2), 0);
        chk("mid_w1", int'(w1), 0);
        chk("mid_w2", int'(w2), 0);
        chk("mid_bias", int'(bias), 0);
        chk("mid_out_y", int'(out_y), 0);
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_out_idx", int'(out_idx), 0);
        @(posedge clk);
        #1;
        cfg_write(0, -1); cfg_write(2, 0);
        send_sample(0, 0, 0);
        wait_drain();

        // Index wrap
        do_reset();
        cfg_write(0, int'($urandom_range(0, 1023)) - 512);
        cfg_write(1, int'($urandom_range(0, 1023)) - 512);
        for (int s = 0; s < 5; s++)
            send_sample(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
